// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared definitions for the SPI LCD transmit engine:
//                FSM state encoding and D/C line levels.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Transmit FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_SETUP = 3'd1;
    localparam state_t c_ST_SHIFT = 3'd2;
    localparam state_t c_ST_WAIT  = 3'd3;
    localparam state_t c_ST_GAP   = 3'd4;

    // Level driven on the panel D/C pin
    localparam logic c_DC_CMD  = 1'b0;
    localparam logic c_DC_DATA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/lcd_spi_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_spi_fifo
//  Description : Synchronous show-ahead FIFO holding queued LCD words.
//                o_rd_data always presents the head entry; i_pop retires it.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_push/i_wr_data - write an entry (ignored when full)
//                i_pop           - retire head entry (ignored when empty)
//                o_rd_data       - head entry
//                o_full/o_empty  - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [c_AW:0]      r_wptr;
    logic [c_AW:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_wr_en;
    logic               w_rd_en;

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                       (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign o_rd_data = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + (c_AW+1)'(1);
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + (c_AW+1)'(1);
            end
        end
    end

    // Storage is not reset; contents are only observable behind a valid pointer
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[c_AW-1:0]] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_spi_tx
//  Description : SPI transmit engine for ST7789-class LCD panels. Queues
//                words with per-word length (8 or WORD_W bits), D/C level and
//                burst-end flag, and serialises them MSB first with CS held
//                low across a burst.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                in_valid/ready - word handshake
//                in_data        - word, MSB first (8-bit words use [7:0])
//                in_wide        - 1: WORD_W bits, 0: 8 bits
//                in_dc          - D/C level for this word
//                in_last        - release CS after this word
//                busy           - queue non-empty or transfer in progress
//                lcd_spi_*      - SCLK / MOSI / CS_n panel pins (registered)
//                lcd_dc         - D/C panel pin (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_tx
    import lcd_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int CLK_DIV    = 2,
    parameter int CPOL       = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_wide,
    input  logic              in_dc,
    input  logic              in_last,
    output logic              busy,
    output logic              lcd_spi_sclk,
    output logic              lcd_spi_mosi,
    output logic              lcd_spi_cs,
    output logic              lcd_dc
);

    localparam int c_DIV_W   = $clog2(CLK_DIV + 1);
    localparam int c_BIT_W   = $clog2(WORD_W + 1);
    localparam int c_GAP_CYC = (CS_GAP < 1) ? 1 : CS_GAP;
    localparam int c_GAP_W   = $clog2(c_GAP_CYC + 1);
    localparam int c_ENT_W   = WORD_W + 3;

    localparam logic               c_SCLK_IDLE = (CPOL != 0);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(c_GAP_CYC - 1);

    // ------------------------------------------------------------------
    // Input queue
    // ------------------------------------------------------------------
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [c_ENT_W-1:0] w_wr_ent;
    logic [c_ENT_W-1:0] w_rd_ent;
    logic [WORD_W-1:0]  w_q_data;
    logic [WORD_W-1:0]  w_q_align;
    logic               w_q_wide;
    logic               w_q_dc;
    logic               w_q_last;

    assign in_ready = !rst && !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_wr_ent = {in_last, in_dc, in_wide, in_data};

    assign {w_q_last, w_q_dc, w_q_wide, w_q_data} = w_rd_ent;

    // Short words are left-aligned so the shifter always emits from the MSB;
    // the upper input bits of a short word fall off the top.
    assign w_q_align = w_q_wide ? w_q_data : (w_q_data << (WORD_W - 8));

    lcd_spi_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wr_data (w_wr_ent),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_ent),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // ------------------------------------------------------------------
    // Transmit FSM, divider and shifter
    // ------------------------------------------------------------------
    state_t              r_state,  w_state_nxt;
    logic [c_DIV_W-1:0]  r_div,    w_div_nxt;
    logic [c_BIT_W-1:0]  r_bits,   w_bits_nxt;
    logic [c_GAP_W-1:0]  r_gap,    w_gap_nxt;
    logic [WORD_W-1:0]   r_shreg,  w_shreg_nxt;
    logic                r_last,   w_last_nxt;
    logic                r_sclk,   w_sclk_nxt;
    logic                r_mosi,   w_mosi_nxt;
    logic                r_cs,     w_cs_nxt;
    logic                r_dc,     w_dc_nxt;
    logic                w_start;
    logic                w_trailing;

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bits_nxt  = r_bits;
        w_gap_nxt   = r_gap;
        w_shreg_nxt = r_shreg;
        w_last_nxt  = r_last;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_cs_nxt    = r_cs;
        w_dc_nxt    = r_dc;
        w_pop       = 1'b0;
        w_start     = 1'b0;
        // The edge about to happen returns SCLK to its idle level
        w_trailing  = (r_sclk != c_SCLK_IDLE);

        case (r_state)
            c_ST_IDLE: begin
                w_cs_nxt = 1'b1;
                if (!w_empty) begin
                    w_start = 1'b1;
                end
            end

            c_ST_SETUP: begin
                // The SETUP edge is always the leading edge of the MSB; MOSI
                // already holds the MSB so nothing shifts here.
                if (r_div == c_DIV_LAST) begin
                    w_div_nxt   = '0;
                    w_sclk_nxt  = ~r_sclk;
                    w_state_nxt = c_ST_SHIFT;
                end else begin
                    w_div_nxt = r_div + c_DIV_W'(1);
                end
            end

            c_ST_SHIFT: begin
                if (r_div == c_DIV_LAST) begin
                    w_div_nxt = '0;
                    if (r_bits == '0) begin
                        // Final half-period after the last trailing edge done
                        if (r_last) begin
                            w_state_nxt = c_ST_GAP;
                            w_cs_nxt    = 1'b1;
                            w_gap_nxt   = '0;
                        end else if (!w_empty) begin
                            w_start = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_WAIT;
                        end
                    end else begin
                        w_sclk_nxt = ~r_sclk;
                        if (w_trailing) begin
                            w_bits_nxt = r_bits - c_BIT_W'(1);
                        end
                        // Data moves only on falling SCLK so it is stable at
                        // every rising (sampling) edge in both modes. The
                        // falling edge that ends the last bit in mode 0 has
                        // nothing left to present.
                        if (r_sclk && !(w_trailing && (r_bits == c_BIT_W'(1)))) begin
                            w_shreg_nxt = r_shreg << 1;
                            w_mosi_nxt  = r_shreg[WORD_W-2];
                        end
                    end
                end else begin
                    w_div_nxt = r_div + c_DIV_W'(1);
                end
            end

            c_ST_WAIT: begin
                if (!w_empty) begin
                    w_start = 1'b1;
                end
            end

            c_ST_GAP: begin
                w_cs_nxt = 1'b1;
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap + c_GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Pop the head entry and present its MSB and D/C during SETUP
        if (w_start) begin
            w_pop       = 1'b1;
            w_state_nxt = c_ST_SETUP;
            w_div_nxt   = '0;
            w_shreg_nxt = w_q_align;
            w_mosi_nxt  = w_q_align[WORD_W-1];
            w_bits_nxt  = w_q_wide ? c_BIT_W'(WORD_W) : c_BIT_W'(8);
            w_last_nxt  = w_q_last;
            w_dc_nxt    = w_q_dc;
            w_cs_nxt    = 1'b0;
            w_sclk_nxt  = c_SCLK_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_div   <= '0;
            r_bits  <= '0;
            r_gap   <= '0;
            r_shreg <= '0;
            r_last  <= 1'b0;
            r_sclk  <= c_SCLK_IDLE;
            r_mosi  <= 1'b0;
            r_cs    <= 1'b1;
            r_dc    <= c_DC_CMD;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bits  <= w_bits_nxt;
            r_gap   <= w_gap_nxt;
            r_shreg <= w_shreg_nxt;
            r_last  <= w_last_nxt;
            r_sclk  <= w_sclk_nxt;
            r_mosi  <= w_mosi_nxt;
            r_cs    <= w_cs_nxt;
            r_dc    <= w_dc_nxt;
        end
    end

    assign busy         = !w_empty || (r_state != c_ST_IDLE);
    assign lcd_spi_sclk = r_sclk;
    assign lcd_spi_mosi = r_mosi;
    assign lcd_spi_cs   = r_cs;
    assign lcd_dc       = r_dc;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_spi_tx
//  Description : Self-checking bench for lcd_spi_tx. Two instances (CPOL=0
//                and CPOL=1) share one stimulus; a bit-level monitor per
//                instance reassembles words on rising SCLK and compares them
//                against a scoreboard queue filled at handshake time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_tx;
    import lcd_pkg::*;

    localparam int WORD_W     = 16;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CS_GAP     = 2;

    typedef struct packed {
        logic [15:0] data;
        logic        wide;
        logic        dc;
        logic        last;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_wide;
    logic              in_dc;
    logic              in_last;
    logic [1:0]        in_ready;
    logic [1:0]        busy;
    logic [1:0]        sclk;
    logic [1:0]        mosi;
    logic [1:0]        cs;
    logic [1:0]        dc;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    int   rd_idx[2];
    int   bit_cnt[2];
    int   rise_tot[2];
    int   idle_bad[2];
    int   low_len[2];
    int   high_len[2];
    int   last_low_len[2];
    logic [15:0] acc[2];
    exp_t cur[2];
    logic cur_ok[2];
    logic dc_ok[2];
    logic last_done[2];
    logic seen_low[2];
    logic prev_sclk[2];
    logic prev_cs[2];
    logic saw_stall;
    int   snap[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        lcd_spi_tx #(
            .WORD_W     (WORD_W),
            .CLK_DIV    (CLK_DIV),
            .CPOL       (m),
            .FIFO_DEPTH (FIFO_DEPTH),
            .CS_GAP     (CS_GAP)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid),
            .in_ready     (in_ready[m]),
            .in_data      (in_data),
            .in_wide      (in_wide),
            .in_dc        (in_dc),
            .in_last      (in_last),
            .busy         (busy[m]),
            .lcd_spi_sclk (sclk[m]),
            .lcd_spi_mosi (mosi[m]),
            .lcd_spi_cs   (cs[m]),
            .lcd_dc       (dc[m])
        );
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Pin monitor: rebuild words on rising SCLK, police CS framing
    // ------------------------------------------------------------------
    initial begin
        for (int m = 0; m < 2; m++) begin
            rd_idx[m] = 0; bit_cnt[m] = 0; rise_tot[m] = 0; idle_bad[m] = 0;
            low_len[m] = 0; high_len[m] = 0; last_low_len[m] = 0;
            seen_low[m] = 1'b0; last_done[m] = 1'b1; prev_cs[m] = 1'b1;
            prev_sclk[m] = 1'b0; cur_ok[m] = 1'b0; dc_ok[m] = 1'b1; acc[m] = '0;
        end
    end

    always @(posedge clk) begin
        #1;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                bit_cnt[m]   = 0;
                rd_idx[m]    = exp_q.size();
                low_len[m]   = 0;
                high_len[m]  = 0;
                seen_low[m]  = 1'b0;
                last_done[m] = 1'b1;
                cur_ok[m]    = 1'b0;
            end else if (cs[m]) begin
                if (sclk[m] !== logic'(m == 1)) idle_bad[m]++;
                if (!prev_cs[m]) begin
                    check_value($sformatf("m%0d_cs_rise_partial", m), bit_cnt[m], 0);
                    check_value($sformatf("m%0d_cs_rise_after_last", m), last_done[m], 1);
                    last_low_len[m] = low_len[m];
                    low_len[m]  = 0;
                    high_len[m] = 0;
                end
                high_len[m]++;
            end else begin
                if (prev_cs[m] && seen_low[m])
                    check_value($sformatf("m%0d_cs_gap_ok", m), (high_len[m] >= CS_GAP), 1);
                seen_low[m] = 1'b1;
                low_len[m]++;
                if (sclk[m] && !prev_sclk[m]) begin
                    rise_tot[m]++;
                    if (bit_cnt[m] == 0) begin
                        cur_ok[m] = (rd_idx[m] < exp_q.size());
                        if (cur_ok[m]) cur[m] = exp_q[rd_idx[m]];
                        acc[m]   = '0;
                        dc_ok[m] = 1'b1;
                    end
                    if (!cur_ok[m]) begin
                        check_value($sformatf("m%0d_unexpected_bit", m), 1, 0);
                    end else begin
                        acc[m]   = {acc[m][14:0], mosi[m]};
                        dc_ok[m] = dc_ok[m] && (dc[m] === cur[m].dc);
                        bit_cnt[m]++;
                        if (bit_cnt[m] == (cur[m].wide ? 16 : 8)) begin
                            check_value($sformatf("m%0d_word_data", m), acc[m],
                                        cur[m].wide ? cur[m].data : {8'h00, cur[m].data[7:0]});
                            check_value($sformatf("m%0d_word_dc", m), dc_ok[m], 1);
                            last_done[m] = cur[m].last;
                            rd_idx[m]++;
                            bit_cnt[m] = 0;
                        end
                    end
                end
            end
            prev_sclk[m] = sclk[m];
            prev_cs[m]   = cs[m];
        end
        // Retire scoreboard entries once both instances have emitted them
        while (rd_idx[0] > 0 && rd_idx[1] > 0) begin
            void'(exp_q.pop_front());
            rd_idx[0]--;
            rd_idx[1]--;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send(input logic [15:0] d, input logic w, input logic dcv, input logic l);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_wide = w; in_dc = dcv; in_last = l;
        while (in_ready !== 2'b11 && n < 500) begin
            saw_stall = 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            check_value("send_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            e.data = d; e.wide = w; e.dc = dcv; e.last = l;
            exp_q.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n = 0;
        while ((busy !== 2'b00 || exp_q.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check_value(tag, (n < max), 1);
    endtask

    task automatic take_snap();
        snap[0] = rise_tot[0];
        snap[1] = rise_tot[1];
    endtask

    task automatic check_edges(input string tag, input int exp_edges);
        for (int m = 0; m < 2; m++)
            check_value($sformatf("%s_m%0d", tag, m), rise_tot[m] - snap[m], exp_edges);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int bad;
        logic [7:0] bp_data [6];

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_wide = 1'b0;
        in_dc = 1'b0; in_last = 1'b0; saw_stall = 1'b0;

        // 1: reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_value("rst_in_ready", in_ready, 2'b00);
        check_value("rst_cs", cs, 2'b11);
        check_value("rst_sclk", sclk, 2'b10);
        check_value("rst_mosi", mosi, 2'b00);
        check_value("rst_dc", dc, 2'b00);
        check_value("rst_busy", busy, 2'b00);
        rst = 1'b0;
        #1 check_value("post_rst_in_ready", in_ready, 2'b11);

        // 2: single 8-bit command
        take_snap();
        send(16'h002C, 1'b0, c_DC_CMD, 1'b1);
        wait_drain("t2_drain", 300);
        check_edges("t2_edges", 8);
        check_value("t2_cs_low_len_m0", last_low_len[0], 34);
        check_value("t2_cs_low_len_m1", last_low_len[1], 34);

        // 3: three-word RGB565 data burst
        take_snap();
        send(16'hF800, 1'b1, c_DC_DATA, 1'b0);
        send(16'h07E0, 1'b1, c_DC_DATA, 1'b0);
        send(16'h001F, 1'b1, c_DC_DATA, 1'b1);
        wait_drain("t3_drain", 600);
        check_edges("t3_edges", 48);

        // 4: upstream stall inside a burst
        take_snap();
        send(16'h00A1, 1'b0, c_DC_CMD, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        check_value("t4_word1_done", (n < 300), 1);
        repeat (6) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cs !== 2'b00)   bad++;
            if (sclk !== 2'b10) bad++;
            if (busy !== 2'b11) bad++;
        end
        check_value("t4_wait_hold", bad, 0);
        check_edges("t4_wait_edges", 8);
        send(16'h5A3C, 1'b1, c_DC_DATA, 1'b1);
        wait_drain("t4_drain", 300);
        check_edges("t4_edges", 24);

        // 5: backpressure with six back-to-back words
        bp_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        take_snap();
        saw_stall = 1'b0;
        for (int i = 0; i < 6; i++)
            send({8'hEE, bp_data[i]}, 1'b0, logic'(i % 2), logic'(i == 2 || i == 5));
        check_value("t5_backpressure", saw_stall, 1);
        wait_drain("t5_drain", 800);
        check_edges("t5_edges", 48);

        // 6: reset in the middle of a word, with a second word queued
        take_snap();
        send(16'hC3F0, 1'b1, c_DC_DATA, 1'b1);
        send(16'h0077, 1'b0, c_DC_DATA, 1'b1);
        n = 0;
        while (bit_cnt[0] < 5 && n < 200) begin @(negedge clk); n++; end
        check_value("t6_reach_bit5", (n < 200), 1);
        rst = 1'b1;
        @(negedge clk);
        check_value("t6_rst_cs", cs, 2'b11);
        check_value("t6_rst_sclk", sclk, 2'b10);
        check_value("t6_rst_busy", busy, 2'b00);
        check_value("t6_rst_in_ready", in_ready, 2'b00);
        rst = 1'b0;
        take_snap();
        send(16'h00A5, 1'b0, c_DC_DATA, 1'b1);
        wait_drain("t6_drain", 300);
        check_edges("t6_edges", 8);

        repeat (5) @(negedge clk);
        check_value("idle_sclk_m0", idle_bad[0], 0);
        check_value("idle_sclk_m1", idle_bad[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
